// File: rtl/alu_pkg.sv
// Shared ALU definitions: unit tags (the alu_fun encoding), default width,
// the collector's entry record and a one-hot-to-tag helper.
package alu_pkg;

    localparam int unsigned ALU_OUT_W = 16;
    localparam int unsigned TAG_W     = 2;

    localparam logic [TAG_W-1:0] TAG_ARITH = 2'b00;
    localparam logic [TAG_W-1:0] TAG_LOGIC = 2'b01;
    localparam logic [TAG_W-1:0] TAG_CMP   = 2'b10;
    localparam logic [TAG_W-1:0] TAG_SHIFT = 2'b11;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic                 carry;
        logic [ALU_OUT_W-1:0] res;
    } entry_t;

    // Valid vector order is {shift, cmp, logic, arith}; caller guarantees one-hot.
    function automatic logic [TAG_W-1:0] onehot_tag(input logic [3:0] vld);
        logic [TAG_W-1:0] tag;
        tag = TAG_ARITH;
        if (vld[1]) tag = TAG_LOGIC;
        if (vld[2]) tag = TAG_CMP;
        if (vld[3]) tag = TAG_SHIFT;
        return tag;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous DEPTH-entry FIFO with a registered head word; the head reads
// as zero whenever the FIFO is empty.
module alu_res_fifo #(
    parameter int unsigned W     = 19,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         valid_o,
    output logic         full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [W-1:0]     head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop_i && valid_q;
        do_push = push_i && (!full_q || do_pop);
        rd_nxt  = rd_q + PTR_W'(1);
        rd_d    = do_pop  ? rd_nxt : rd_q;
        wr_d    = do_push ? (wr_q + PTR_W'(1)) : wr_q;
        occ_d   = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        valid_d = (occ_d != '0);
        full_d  = (occ_d == OCC_W'(DEPTH));
        head_d  = head_q;
        // Head follows the next stored entry, or the incoming word if it lands in an empty slot.
        if (do_pop) begin
            if (occ_q >= OCC_W'(2)) begin
                head_d = mem_q[rd_nxt];
            end else if (do_push) begin
                head_d = push_data_i;
            end else begin
                head_d = '0;
            end
        end else if (!valid_q && do_push) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            valid_q <= valid_d;
            full_q  <= full_d;
        end
    end

    // Storage needs no reset: only entries behind a valid pointer are ever read.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign full_o  = full_q;

endmodule

// File: rtl/alu_result_collector.sv
// Collects one-hot execution-unit results, tags them by unit, buffers them in a
// FIFO for a valid/ready consumer and keeps sticky error flags and a push count.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int unsigned OUT_W = ALU_OUT_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OUT_W-1:0] arith_res,
    input  logic             arith_carry,
    input  logic             arith_valid,
    input  logic [OUT_W-1:0] logic_res,
    input  logic [OUT_W-1:0] cmp_res,
    input  logic [OUT_W-1:0] shift_res,
    input  logic             logic_valid,
    input  logic             cmp_valid,
    input  logic             shift_valid,
    output logic [OUT_W-1:0] out_res,
    output logic             out_carry,
    output logic [1:0]       out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_multi,
    output logic             err_ovf,
    input  logic             err_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             carry;
        logic [OUT_W-1:0] res;
    } ent_t;

    localparam int unsigned ENT_W = $bits(ent_t);

    logic [3:0]       vld;
    logic [2:0]       nvalid;
    logic             one_hot, multi;
    ent_t             ent_in, ent_head;
    logic [ENT_W-1:0] head_raw;
    logic             fifo_valid, fifo_full;
    logic             pop, push_acc, ovf;

    logic             err_multi_q, err_multi_d;
    logic             err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign vld     = {shift_valid, cmp_valid, logic_valid, arith_valid};
    assign nvalid  = 3'(vld[0]) + 3'(vld[1]) + 3'(vld[2]) + 3'(vld[3]);
    assign one_hot = (nvalid == 3'd1);
    assign multi   = (nvalid >= 3'd2);

    // Entry formation; carry is meaningful only for the arithmetic unit.
    always_comb begin
        ent_in       = '0;
        ent_in.tag   = onehot_tag(vld);
        ent_in.carry = 1'b0;
        unique case (ent_in.tag)
            TAG_ARITH: begin
                ent_in.res   = arith_res;
                ent_in.carry = arith_carry;
            end
            TAG_LOGIC: ent_in.res = logic_res;
            TAG_CMP:   ent_in.res = cmp_res;
            TAG_SHIFT: ent_in.res = shift_res;
            default:   ent_in.res = '0;
        endcase
    end

    assign pop      = fifo_valid && out_ready;
    assign push_acc = one_hot && (!fifo_full || pop);
    assign ovf      = one_hot && fifo_full && !pop;

    alu_res_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_acc),
        .push_data_i (ENT_W'(ent_in)),
        .pop_i       (out_ready),
        .head_o      (head_raw),
        .valid_o     (fifo_valid),
        .full_o      (fifo_full)
    );

    // Sticky flags: a set in the same cycle as err_clr wins.
    always_comb begin
        err_multi_d = err_multi_q;
        err_ovf_d   = err_ovf_q;
        cnt_d       = cnt_q;
        if (err_clr) begin
            err_multi_d = 1'b0;
            err_ovf_d   = 1'b0;
        end
        if (multi) err_multi_d = 1'b1;
        if (ovf)   err_ovf_d   = 1'b1;
        if (push_acc) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_multi_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            err_multi_q <= err_multi_d;
            err_ovf_q   <= err_ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ent_head  = ent_t'(head_raw);
    assign out_res   = ent_head.res;
    assign out_carry = ent_head.carry;
    assign out_tag   = ent_head.tag;
    assign out_valid = fifo_valid;
    assign err_multi = err_multi_q;
    assign err_ovf   = err_ovf_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed and random test of alu_result_collector against a queue-based model.
module tb_alu_result_collector;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] arith_res = '0, logic_res = '0, cmp_res = '0, shift_res = '0;
    logic        arith_carry = 1'b0;
    logic        arith_valid = 1'b0, logic_valid = 1'b0, cmp_valid = 1'b0, shift_valid = 1'b0;
    logic [15:0] out_res;
    logic        out_carry;
    logic [1:0]  out_tag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err_multi, err_ovf;
    logic        err_clr = 1'b0;
    logic [15:0] op_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: queue of {tag, carry, res}
    logic [18:0] mq[$];
    logic [15:0] m_cnt = '0;
    logic        m_em = 1'b0, m_eo = 1'b0;

    alu_result_collector dut (
        .clk(clk), .rst(rst),
        .arith_res(arith_res), .arith_carry(arith_carry), .arith_valid(arith_valid),
        .logic_res(logic_res), .cmp_res(cmp_res), .shift_res(shift_res),
        .logic_valid(logic_valid), .cmp_valid(cmp_valid), .shift_valid(shift_valid),
        .out_res(out_res), .out_carry(out_carry), .out_tag(out_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_multi(err_multi), .err_ovf(err_ovf), .err_clr(err_clr),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge: advance the model from the current inputs, then compare.
    task automatic tick();
        int          nv;
        logic        pop, acc;
        logic [18:0] e;
        logic [18:0] hd;
        nv = int'(arith_valid) + int'(logic_valid) + int'(cmp_valid) + int'(shift_valid);
        if (!rst) begin
            mq.delete();
            m_cnt = '0;
            m_em  = 1'b0;
            m_eo  = 1'b0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            acc = (nv == 1) && (mq.size() < DEPTH || pop);
            if (err_clr) begin m_em = 1'b0; m_eo = 1'b0; end
            if (nv >= 2) m_em = 1'b1;
            if (nv == 1 && mq.size() == DEPTH && !pop) m_eo = 1'b1;
            if (arith_valid)      e = {2'b00, arith_carry, arith_res};
            else if (logic_valid) e = {2'b01, 1'b0, logic_res};
            else if (cmp_valid)   e = {2'b10, 1'b0, cmp_res};
            else                  e = {2'b11, 1'b0, shift_res};
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(e);
                m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        hd = (mq.size() > 0) ? mq[0] : 19'd0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("out_tag",   32'(out_tag),   32'(hd[18:17]));
        chk("out_carry", 32'(out_carry), 32'(hd[16]));
        chk("out_res",   32'(out_res),   32'(hd[15:0]));
        chk("op_count",  32'(op_count),  32'(m_cnt));
        chk("err_multi", 32'(err_multi), 32'(m_em));
        chk("err_ovf",   32'(err_ovf),   32'(m_eo));
    endtask

    // Set unit valids ({shift,cmp,logic,arith}); the named result goes to every unit,
    // distinguished by XOR masks so a wrong mux is visible.
    task automatic drive(input logic [3:0] v, input logic [15:0] r, input logic c);
        arith_valid = v[0];
        logic_valid = v[1];
        cmp_valid   = v[2];
        shift_valid = v[3];
        arith_res   = v[0] ? r : r ^ 16'h1111;
        logic_res   = v[1] ? r : r ^ 16'h2222;
        cmp_res     = v[2] ? r : r ^ 16'h4444;
        shift_res   = v[3] ? r : r ^ 16'h8888;
        arith_carry = c;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        rst = 1'b1;
        tick();

        // Single logic op
        drive(4'b0010, 16'h00F0, 1'b0);
        tick();
        drive(4'b0000, 16'h0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_tag",   32'(out_tag),   32'h1);
        chk("single_res",   32'(out_res),   32'h00F0);
        chk("single_cnt",   32'(op_count),  32'd1);
        tick();
        out_ready = 1'b1;
        tick();

        // Arith with carry, drained immediately
        drive(4'b0001, 16'hFFFE, 1'b1);
        tick();
        drive(4'b0000, 16'h0, 1'b0);
        chk("arith_beat", {13'd0, out_valid, out_tag, out_carry, out_res}, {13'd1, 2'b00, 1'b1, 16'hFFFE});
        tick();
        chk("arith_empty", 32'(out_valid), 32'd0);

        // Collision
        drive(4'b1100, 16'h1234, 1'b0);
        tick();
        drive(4'b0000, 16'h0, 1'b0);
        chk("coll_err", 32'(err_multi), 32'd1);
        chk("coll_cnt", 32'(op_count),  32'd2);
        chk("coll_nov", 32'(out_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("coll_clr", 32'(err_multi), 32'd0);

        // Overflow
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001 << (i % 4), 16'hA000 + 16'(i), 1'b0);
            tick();
        end
        drive(4'b0000, 16'h0, 1'b0);
        chk("ovf_err", 32'(err_ovf),  32'd1);
        chk("ovf_cnt", 32'(op_count), 32'd6);
        chk("ovf_head", 32'(out_res), 32'hA000);
        out_ready = 1'b1;
        drive(4'b0100, 16'hB00B, 1'b0);
        tick();
        drive(4'b0000, 16'h0, 1'b0);
        chk("full_pp_cnt", 32'(op_count), 32'd7);
        chk("full_pp_head", 32'(out_res), 32'hA001);
        for (int i = 0; i < 5; i++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(err_ovf), 32'd0);

        // Streaming with ready toggling
        for (int i = 0; i < 8; i++) begin
            drive(4'b0001 << (i % 4), 16'(i * 16'h0101), 1'(i & 1));
            out_ready = 1'(i & 1);
            tick();
        end
        drive(4'b0000, 16'h0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            out_ready = 1'(i & 1);
            tick();
        end
        chk("stream_cnt", 32'(op_count), 32'd15);
        chk("stream_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'b1000, 16'hC000 + 16'(i), 1'b0);
            tick();
        end
        drive(4'b0000, 16'h0, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt",   32'(op_count),  32'd0);
        drive(4'b0010, 16'h5A5A, 1'b0);
        tick();
        drive(4'b0000, 16'h0, 1'b0);
        out_ready = 1'b1;
        chk("post_rst_res", 32'(out_res), 32'h5A5A);
        tick();
        chk("post_rst_alone", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)       drive(4'b0001 << r, 16'($urandom), 1'($urandom));
            else if (r == 4) drive(4'($urandom) | 4'b0011, 16'($urandom), 1'($urandom));
            else             drive(4'b0000, 16'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 59) != 0);
            tick();
        end
        rst = 1'b1;
        err_clr = 1'b0;
        drive(4'b0000, 16'h0, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Downstream stage of the structural ALU. Gathers the registered results of the four execution units (arithmetic, logic, compare, shift), checks that exactly one unit reported a result, tags it with the originating unit's `alu_fun` code and buffers it in a small FIFO. The FIFO drains to the consumer over a valid/ready handshake. Sticky error flags and a completed-operation counter support debug.

## Interface
Parameters:
- `OUT_W`, default 16: result width of every unit (arith result already widened to `OUT_W`).
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `CNT_W`, default 16: width of `op_count`.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset.
- `arith_res`  in  OUT_W  arithmetic unit result.
- `arith_carry`  in  1  arithmetic carry/borrow.
- `arith_valid`  in  1  arithmetic result valid this cycle.
- `logic_res`, `cmp_res`, `shift_res`  in  OUT_W  each: logic, compare and shift unit results.
- `logic_valid`, `cmp_valid`, `shift_valid`  in  1  each: matching result valids.
- `out_res`  out  OUT_W  head-of-FIFO result.
- `out_carry`  out  1  head carry; 0 for non-arith entries.
- `out_tag`  out  2  originating unit: 00 arith, 01 logic, 10 cmp, 11 shift.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  consumer accepts head.
- `err_multi`  out  1  sticky: more than one unit valid in one cycle.
- `err_ovf`  out  1  sticky: result dropped because the FIFO was full.
- `err_clr`  in  1  clears both sticky flags.
- `op_count`  out  CNT_W  number of entries pushed; wraps modulo 2^CNT_W.

## Operation
- Per cycle, `nvalid` is the number of asserted `*_valid` inputs.
  - `nvalid == 0`: no action.
  - `nvalid == 1`: form entry {tag, carry, res}. `carry` is `arith_carry` for arith and 0 otherwise. Push the entry when accepted (rule below).
  - `nvalid >= 2`: push nothing and set `err_multi`. `op_count` does not change.
- Pop occurs when `out_valid && out_ready`.
- Push acceptance: a push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Full with no pop: the push is dropped, `err_ovf` is set and `op_count` does not change.
- Empty FIFO with push and pop in the same cycle: no pop happens because `out_valid` is 0. The push is accepted.
- `op_count` increments by 1 per accepted push and wraps from all-ones to 0.
- `err_clr` clears the sticky flags. If a set condition occurs in the same cycle, set wins.
- `out_*` are driven from the head entry. When the FIFO is empty, `out_res`, `out_carry` and `out_tag` hold 0.
- Occupancy counter range is 0..DEPTH. Read and write pointers wrap modulo DEPTH.

## Timing
- All state updates on the rising `clk` edge.
- Reset (`rst` = 0 at an edge) clears pointers, occupancy, `op_count`, `err_multi` and `err_ovf`. It forces `out_valid`=0 and `out_res`/`out_carry`/`out_tag`=0. Entries held in the FIFO are discarded.
- Reset applied mid-stream has priority over push, pop and `err_clr` in the same cycle.
- Latency: a unit valid sampled at edge N into an empty FIFO gives `out_valid`=1 with that data after edge N, i.e. one cycle later.
- Throughput: one push and one pop per cycle sustained. Full bandwidth is reached with `out_ready` held high.
- `out_*` may change only after a pop or when the FIFO goes from empty to non-empty. They stay stable while `out_valid && !out_ready`.
- The sticky flags assert on the edge following the offending cycle.

## Structure
- Shared package `alu_pkg`:
  - tag constants `TAG_ARITH`=2'b00, `TAG_LOGIC`=2'b01, `TAG_CMP`=2'b10, `TAG_SHIFT`=2'b11. These match the `alu_fun` encoding used by the unit-enable decode.
  - the entry record type {tag, carry, res}.
  - the default `OUT_W`.
- Sub-module `alu_res_fifo`: a synchronous DEPTH-entry FIFO with push/pop/full/empty and a registered head.
- The top level holds the one-hot check, tag encode, error flags and counter.

## Test plan
- Single op: reset, then `logic_valid`=1 with `logic_res`=16'h00F0 for one cycle → next cycle `out_valid`=1, `out_tag`=01, `out_res`=16'h00F0, `out_carry`=0, `op_count`=1.
- Arith carry: `arith_valid` with res 16'hFFFE and carry=1, `out_ready`=1 → one beat {00, 1, FFFE}, then `out_valid`=0.
- Collision: `cmp_valid` and `shift_valid` high in the same cycle → no entry, `err_multi`=1, `op_count` unchanged. After `err_clr` pulse, `err_multi`=0.
- Overflow: `out_ready`=0, push 5 results with DEPTH=4 → first 4 held in order, 5th dropped, `err_ovf`=1, `op_count`=4. Then a push with a simultaneous pop while full → accepted, no error.
- Streaming with backpressure: 8 results with tags 00,01,10,11 repeating, `out_ready` toggling every cycle → all 8 delivered in order and stable while stalled, `op_count`=8.
- Reset mid-stream: with 3 entries held, pull `rst` low for one edge → `out_valid`=0, `op_count`=0, flags 0. After release the next pushed result is delivered alone.
